// File: rtl/pixel_frame_loader.sv
// Pixel frame loader: collects nine serial pixel bits into a parallel frame
// (X_0..X_8). It presents the frame to the downstream mean/variance stage and
// holds it until that stage acknowledges it. It also counts acknowledged frames.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no pixels held, pix_count = 0, ready for the first pixel
// FILL  | 1..8 pixels held, still accepting
// FULL  | 9 pixels held, frame_valid = 1, waiting for frame_ack
module pixel_frame_loader #(
    parameter int FRAME_CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pix_in,
    input  logic                   pix_valid,
    output logic                   pix_ready,
    input  logic                   frame_abort,
    output logic                   X_0,
    output logic                   X_1,
    output logic                   X_2,
    output logic                   X_3,
    output logic                   X_4,
    output logic                   X_5,
    output logic                   X_6,
    output logic                   X_7,
    output logic                   X_8,
    output logic                   frame_valid,
    input  logic                   frame_ack,
    output logic [3:0]             pix_count,
    output logic [FRAME_CNT_W-1:0] frames_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        FULL = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [8:0] pix_reg;
    logic       accept;
    logic       ack_take;

    // pix_ready comes only from the state register, so abort is the only
    // input that can veto an accept.
    assign accept   = pix_valid && pix_ready && !frame_abort;
    assign ack_take = (state == FULL) && frame_ack && !frame_abort;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; abort overrides every other event
    always_comb begin
        state_nxt = state;
        if (frame_abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: if (accept) state_nxt = FILL;
                FILL: if (accept && (pix_count == 4'd8)) state_nxt = FULL;
                FULL: if (frame_ack) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Outputs decoded purely from the state register
    always_comb begin
        pix_ready   = (state != FULL);
        frame_valid = (state == FULL);
    end

    // Pixel storage, fill counter and acknowledged-frame counter
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_reg     <= '0;
            pix_count   <= '0;
            frames_done <= '0;
        end else if (frame_abort) begin
            pix_reg   <= '0;
            pix_count <= '0;
        end else if (accept) begin
            // The k-th pixel lands in X_k. Earlier bits stay where they are.
            for (int k = 0; k < 9; k++) begin
                if (pix_count == 4'(k)) pix_reg[k] <= pix_in;
            end
            pix_count <= pix_count + 4'd1;
        end else if (ack_take) begin
            pix_reg     <= '0;
            pix_count   <= '0;
            frames_done <= frames_done + FRAME_CNT_W'(1);
        end
    end

    assign X_0 = pix_reg[0];
    assign X_1 = pix_reg[1];
    assign X_2 = pix_reg[2];
    assign X_3 = pix_reg[3];
    assign X_4 = pix_reg[4];
    assign X_5 = pix_reg[5];
    assign X_6 = pix_reg[6];
    assign X_7 = pix_reg[7];
    assign X_8 = pix_reg[8];

endmodule

// File: tb/tb_pixel_frame_loader.sv
// Directed bench for pixel_frame_loader. Two instances share all inputs.
// One uses the default 8-bit frame counter and one uses a 2-bit counter,
// so counter wrap is observable. Expected frames go into a scoreboard queue
// as they are driven and are popped when frame_valid appears.
module tb_pixel_frame_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       pix_in;
    logic       pix_valid;
    logic       frame_abort;
    logic       frame_ack;

    logic       pix_ready;
    logic       frame_valid;
    logic       x_0, x_1, x_2, x_3, x_4, x_5, x_6, x_7, x_8;
    logic [3:0] pix_count;
    logic [7:0] frames_done;

    logic       w2_pix_ready;
    logic       w2_frame_valid;
    logic       w2_x_0, w2_x_1, w2_x_2, w2_x_3, w2_x_4, w2_x_5, w2_x_6, w2_x_7, w2_x_8;
    logic [3:0] w2_pix_count;
    logic [1:0] w2_frames_done;

    int         pass_cnt  = 0;
    int         total_cnt = 0;
    logic [8:0] sb[$];
    logic [8:0] px;

    pixel_frame_loader dut (
        .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid),
        .pix_ready(pix_ready), .frame_abort(frame_abort),
        .X_0(x_0), .X_1(x_1), .X_2(x_2), .X_3(x_3), .X_4(x_4),
        .X_5(x_5), .X_6(x_6), .X_7(x_7), .X_8(x_8),
        .frame_valid(frame_valid), .frame_ack(frame_ack),
        .pix_count(pix_count), .frames_done(frames_done)
    );

    pixel_frame_loader #(.FRAME_CNT_W(2)) dut_w2 (
        .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid),
        .pix_ready(w2_pix_ready), .frame_abort(frame_abort),
        .X_0(w2_x_0), .X_1(w2_x_1), .X_2(w2_x_2), .X_3(w2_x_3), .X_4(w2_x_4),
        .X_5(w2_x_5), .X_6(w2_x_6), .X_7(w2_x_7), .X_8(w2_x_8),
        .frame_valid(w2_frame_valid), .frame_ack(frame_ack),
        .pix_count(w2_pix_count), .frames_done(w2_frames_done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [8:0] x_vec();
        return {x_8, x_7, x_6, x_5, x_4, x_3, x_2, x_1, x_0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pop_check();
        chk("frame_valid_seen", 32'(frame_valid), 1);
        chk("sb_nonempty", 32'(sb.size() != 0), 1);
        if (frame_valid && sb.size() != 0) begin
            logic [8:0] e;
            e = sb.pop_front();
            chk("frame_x", 32'(x_vec()), 32'(e));
        end
    endtask

    task automatic run_frame(input logic [8:0] p);
        sb.push_back(p);
        for (int k = 0; k < 9; k++) begin
            pix_valid = 1'b1;
            pix_in    = p[k];
            tick();
            chk("fill_count", 32'(pix_count), 32'(k + 1));
            if (k < 8) chk("fill_not_valid", 32'(frame_valid), 0);
        end
        pix_valid = 1'b0;
        chk("full_ready", 32'(pix_ready), 0);
        chk("full_count", 32'(pix_count), 9);
        pop_check();
    endtask

    task automatic ack_frame(input int exp8, input int exp2);
        frame_ack = 1'b1;
        pix_valid = 1'b1;
        pix_in    = 1'b1;
        tick();
        frame_ack = 1'b0;
        pix_valid = 1'b0;
        chk("ack_done8", 32'(frames_done), 32'(exp8));
        chk("ack_done2", 32'(w2_frames_done), 32'(exp2));
        chk("ack_count", 32'(pix_count), 0);
        chk("ack_x", 32'(x_vec()), 0);
        chk("ack_valid", 32'(frame_valid), 0);
        chk("ack_ready", 32'(pix_ready), 1);
    endtask

    initial begin
        rst = 1'b1; pix_in = 1'b0; pix_valid = 1'b0; frame_abort = 1'b0; frame_ack = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_ready", 32'(pix_ready), 1);
        chk("rst_valid", 32'(frame_valid), 0);
        chk("rst_count", 32'(pix_count), 0);
        chk("rst_x", 32'(x_vec()), 0);
        chk("rst_done", 32'(frames_done), 0);

        // Continuous stream 1,0,1,1,0,0,1,0,1
        run_frame(9'b101001101);

        // Hold FULL with pixels offered; nothing may change
        for (int i = 0; i < 5; i++) begin
            pix_valid = 1'b1;
            pix_in    = i[0];
            tick();
            chk("hold_x", 32'(x_vec()), 32'h14D);
            chk("hold_count", 32'(pix_count), 9);
            chk("hold_valid", 32'(frame_valid), 1);
        end
        ack_frame(1, 1);

        // Accept resumes the cycle after the ack
        pix_valid = 1'b1; pix_in = 1'b1;
        tick();
        pix_valid = 1'b0;
        chk("resume_count", 32'(pix_count), 1);
        chk("resume_x", 32'(x_vec()), 1);
        frame_abort = 1'b1;
        tick();
        frame_abort = 1'b0;
        chk("abort1_count", 32'(pix_count), 0);
        chk("abort1_x", 32'(x_vec()), 0);

        // Ack while IDLE is ignored
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
        chk("idle_ack_done", 32'(frames_done), 1);
        chk("idle_ack_valid", 32'(frame_valid), 0);

        // Gapped valid: one idle cycle between pixels
        px = 9'b110010110;
        sb.push_back(px);
        for (int k = 0; k < 9; k++) begin
            pix_valid = 1'b1; pix_in = px[k];
            tick();
            chk("gap_count", 32'(pix_count), 32'(k + 1));
            if (k < 8) begin
                pix_valid = 1'b0; pix_in = ~px[k];
                tick();
                chk("gap_hold_count", 32'(pix_count), 32'(k + 1));
                chk("gap_not_valid", 32'(frame_valid), 0);
            end
        end
        pix_valid = 1'b0;
        pop_check();
        ack_frame(2, 2);

        // Four pixels, then abort coinciding with a fifth pixel
        for (int k = 0; k < 4; k++) begin
            pix_valid = 1'b1; pix_in = 1'b1;
            tick();
        end
        chk("pre_abort_count", 32'(pix_count), 4);
        frame_abort = 1'b1; pix_valid = 1'b1; pix_in = 1'b1;
        tick();
        frame_abort = 1'b0; pix_valid = 1'b0;
        chk("abort_count", 32'(pix_count), 0);
        chk("abort_x", 32'(x_vec()), 0);
        chk("abort_done", 32'(frames_done), 2);
        tick();
        chk("abort_after_count", 32'(pix_count), 0);

        // Abort together with ack in FULL: no count
        run_frame(9'h0F0);
        frame_abort = 1'b1; frame_ack = 1'b1;
        tick();
        frame_abort = 1'b0; frame_ack = 1'b0;
        chk("abort_ack_done8", 32'(frames_done), 2);
        chk("abort_ack_done2", 32'(w2_frames_done), 2);
        chk("abort_ack_valid", 32'(frame_valid), 0);
        chk("abort_ack_x", 32'(x_vec()), 0);

        // Three more frames: 2-bit counter goes 3,0,1
        for (int f = 0; f < 3; f++) begin
            px = 9'($urandom);
            run_frame(px);
            ack_frame(3 + f, (3 + f) % 4);
        end

        // Reset in FULL together with ack
        run_frame(9'h1FF);
        rst = 1'b1; frame_ack = 1'b1;
        tick();
        rst = 1'b0; frame_ack = 1'b0;
        chk("rst_full_done8", 32'(frames_done), 0);
        chk("rst_full_done2", 32'(w2_frames_done), 0);
        chk("rst_full_x", 32'(x_vec()), 0);
        chk("rst_full_valid", 32'(frame_valid), 0);
        chk("rst_full_count", 32'(pix_count), 0);
        chk("rst_full_ready", 32'(pix_ready), 1);
        tick();
        chk("rst_full_ready2", 32'(pix_ready), 1);

        // Reset mid-fill discards the partial frame
        for (int k = 0; k < 3; k++) begin
            pix_valid = 1'b1; pix_in = 1'b1;
            tick();
        end
        pix_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_fill_count", 32'(pix_count), 0);
        chk("rst_fill_x", 32'(x_vec()), 0);
        chk("rst_fill_done", 32'(frames_done), 0);

        chk("sb_drained", 32'(sb.size()), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/pixel_frame_loader.md
PIXEL_FRAME_LOADER -- requirements
Module: pixel_frame_loader

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk is the single clock, all state changes on the rising edge, and rst is sampled only on that edge.
REQ-002 Parameter: FRAME_CNT_W, default 8, width of the completed-frame counter.
REQ-003 clk  in  1  system clock.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 pix_in  in  1  serial pixel bit, 0 or 1.
REQ-006 pix_valid  in  1  pix_in holds a valid pixel this cycle.
REQ-007 pix_ready  out  1  block can accept a pixel this cycle.
REQ-008 frame_abort  in  1  discard partial or held frame.
REQ-009 X_0..X_8  out  1 each  parallel pixel bits presented to the downstream mean/variance stage.
REQ-010 frame_valid  out  1  X_0..X_8 hold a complete 9-pixel frame.
REQ-011 frame_ack  in  1  downstream has consumed the frame.
REQ-012 pix_count  out  4  pixels accepted into the current frame, 0..9.
REQ-013 frames_done  out  FRAME_CNT_W  count of acknowledged frames.

Function
REQ-014 The FSM SHALL have three states: IDLE (pix_count=0), FILL (1..8), FULL (9).
REQ-015 pix_ready SHALL be 1 in IDLE and FILL and 0 in FULL; it is decoded from the state register only, with no input-to-output path.
REQ-016 A pixel SHALL be accepted on any edge where pix_valid=1, pix_ready=1 and frame_abort=0.
REQ-017 The k-th accepted pixel (k=0..8) SHALL be written to X_k; earlier bits hold and no shifting occurs.
REQ-018 pix_count SHALL increment by 1 per accepted pixel.
REQ-019 Transitions: IDLE to FILL on the first accept; FILL to FULL on the 9th accept; FULL to IDLE on frame_ack=1.
REQ-020 frame_valid SHALL be registered and asserted exactly while in FULL, starting the cycle after the 9th accept (latency 1 clk from the last pixel).
REQ-021 In FULL, X_0..X_8 SHALL remain stable until frame_ack; pixels offered in FULL are not accepted.
REQ-022 On frame_ack in FULL: next state IDLE, pix_count=0, X_0..X_8 cleared to 0, frame_valid=0, frames_done incremented by 1.
REQ-023 frames_done SHALL wrap from 2^FRAME_CNT_W-1 to 0.
REQ-024 frame_ack outside FULL SHALL be ignored.
REQ-025 frame_abort=1 in any state SHALL force IDLE, pix_count=0, X_0..X_8=0 and frame_valid=0, with frames_done unchanged.
REQ-026 If frame_abort and an otherwise acceptable pixel coincide, abort SHALL win and the pixel is discarded.
REQ-027 If frame_abort and frame_ack coincide in FULL, abort SHALL win and frames_done does not increment.
REQ-028 pix_valid and frame_ack coinciding in FULL: the ack is processed and the pixel is not accepted (pix_ready=0 that cycle); accept resumes next cycle.
REQ-029 pix_count SHALL never exceed 9.

Reset
REQ-030 rst=1 at an edge SHALL force IDLE, pix_count=0, X_0..X_8=0, frame_valid=0 and frames_done=0, with priority over all other inputs.
REQ-031 pix_ready SHALL read 1 in the first cycle after rst deasserts.
REQ-032 Reset asserted mid-FILL or in FULL SHALL discard the frame without incrementing frames_done.

Verification
REQ-033 Stream 1,0,1,1,0,0,1,0,1 with pix_valid=1 continuously -> frame_valid=1 one cycle after the 9th pixel, X_0..X_8=1,0,1,1,0,0,1,0,1, pix_ready=0, pix_count=9.
REQ-034 Hold FULL for 5 cycles with pix_valid=1, then pulse frame_ack -> X unchanged during the hold, no pixel accepted, next cycle IDLE, frames_done=1.
REQ-035 Gapped pix_valid (pattern 1,0,1,0,...) over 9 pixels -> frame completes after exactly 9 accepts, pix_count tracks 1..9.
REQ-036 Accept 4 pixels, then assert frame_abort together with pix_valid -> pix_count=0, X all 0, frames_done unchanged, 5th pixel not accepted.
REQ-037 FRAME_CNT_W=2, complete and ack 5 frames -> frames_done sequence 1,2,3,0,1.
REQ-038 rst pulsed in FULL with frame_ack=1 same cycle -> all outputs at reset values, frames_done=0, pix_ready=1 next cycle.
